// File: rtl/cla_64_arbiter_pkg.sv
// Shared definitions for the arbitrated 64-bit carry-lookahead adder.
// Op encodings are shared by the requesters and the operand mux.
package cla_64_arbiter_pkg;

   localparam int W = 64;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_ADC = 2'b10,
      OP_SBC = 2'b11
   } op_e;

   // Subtract-type ops feed ~b into the adder.
   function automatic logic op_inverts_b(input op_e op);
      return op[0];
   endfunction

   // Chained ops take their carry-in from the requester's saved carry.
   function automatic logic op_uses_saved_carry(input op_e op);
      return op[1];
   endfunction

endpackage

// File: rtl/cla_64.sv
// 64-bit carry-lookahead adder: sixteen 4-bit lookahead groups with
// group generate/propagate rippling between groups.
module cla_64 (
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        cin,
   output logic [63:0] sum,
   output logic        cout
);

   logic [63:0] g;
   logic [63:0] p;
   logic [16:0] c_grp;

   assign g        = a & b;
   assign p        = a ^ b;
   assign c_grp[0] = cin;
   assign cout     = c_grp[16];

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_grp
         logic [3:0] gg;
         logic [3:0] pp;
         logic [3:0] c;
         logic       grp_g;
         logic       grp_p;

         assign gg    = g[4*gi +: 4];
         assign pp    = p[4*gi +: 4];
         assign c[0]  = c_grp[gi];
         assign c[1]  = gg[0] | (pp[0] & c[0]);
         assign c[2]  = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c[0]);
         assign c[3]  = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                      | (pp[2] & pp[1] & pp[0] & c[0]);
         assign grp_g = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                      | (pp[3] & pp[2] & pp[1] & gg[0]);
         assign grp_p = &pp;

         assign c_grp[gi+1]    = grp_g | (grp_p & c[0]);
         assign sum[4*gi +: 4] = pp ^ c;
      end
   endgenerate

endmodule

// File: rtl/cla_64_arbiter_rr_arbiter.sv
// Round-robin picker: first valid index at or after rr_ptr, wrapping;
// while lock_en is set only lock_id is eligible.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IDW-1:0]  rr_ptr,
   input  logic            lock_en,
   input  logic [IDW-1:0]  lock_id,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_id,
   output logic            grant_any
);

   logic [NREQ-1:0] mask;
   logic [NREQ-1:0] cand;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
         assign mask[gi] = !lock_en || (lock_id == IDW'(gi));
      end
   endgenerate

   assign cand = valid & mask;

   always_comb begin
      int idx;
      grant     = '0;
      grant_id  = '0;
      grant_any = 1'b0;
      idx       = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!grant_any && cand[idx]) begin
            grant[idx] = 1'b1;
            grant_id   = IDW'(idx);
            grant_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cla_64_arbiter.sv
// Shares one cla_64 between NREQ requesters with round-robin arbitration,
// a chaining lock and a single registered, back-pressured result slot.
module cla_64_arbiter
   import cla_64_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [2*NREQ-1:0] req_op,
   input  logic [NREQ-1:0]   req_lock,
   input  logic [W*NREQ-1:0] req_a,
   input  logic [W*NREQ-1:0] req_b,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [W-1:0]      res_sum,
   output logic [IDW-1:0]    res_id,
   output logic              res_carry,
   output logic              res_ovf,
   output logic              res_zero
);

   logic            res_valid_reg;
   logic [W-1:0]    res_sum_reg;
   logic [IDW-1:0]  res_id_reg;
   logic            res_carry_reg;
   logic            res_ovf_reg;
   logic            res_zero_reg;
   logic [NREQ-1:0] carry_q_reg;
   logic [IDW-1:0]  rr_ptr_reg;
   logic [IDW-1:0]  rr_ptr_next;
   logic            lock_en_reg;
   logic [IDW-1:0]  lock_id_reg;

   logic            free;
   logic            accept;
   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  grant_id;
   logic            grant_any;

   op_e             op_sel;
   logic            lock_sel;
   logic            carry_sel;
   logic [W-1:0]    a_sel;
   logic [W-1:0]    b_sel;
   logic [W-1:0]    b_eff;
   logic            cin;
   logic [W-1:0]    sum;
   logic            cout;
   logic            cin_msb;

   assign free = !res_valid_reg || res_ready;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr_arbiter (
      .valid     (req_valid & {NREQ{free}}),
      .rr_ptr    (rr_ptr_reg),
      .lock_en   (lock_en_reg),
      .lock_id   (lock_id_reg),
      .grant     (grant),
      .grant_id  (grant_id),
      .grant_any (grant_any)
   );

   // The grant is combinational, so it must be forced low while reset is held.
   assign req_ready = grant & {NREQ{rst_n}};
   assign accept    = grant_any && rst_n;

   always_comb begin
      op_sel    = OP_ADD;
      lock_sel  = 1'b0;
      carry_sel = 1'b0;
      a_sel     = '0;
      b_sel     = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            op_sel    = op_e'(req_op[2*i +: 2]);
            lock_sel  = req_lock[i];
            carry_sel = carry_q_reg[i];
            a_sel     = req_a[W*i +: W];
            b_sel     = req_b[W*i +: W];
         end
      end
   end

   // Carry 1 means "no borrow", so SUB starts with cin 1 and SBC reuses it.
   always_comb begin
      b_eff = op_inverts_b(op_sel) ? ~b_sel : b_sel;
      if (op_uses_saved_carry(op_sel))
         cin = carry_sel;
      else
         cin = op_inverts_b(op_sel);
   end

   cla_64 u_cla_64 (
      .a    (a_sel),
      .b    (b_eff),
      .cin  (cin),
      .sum  (sum),
      .cout (cout)
   );

   assign cin_msb     = a_sel[W-1] ^ b_eff[W-1] ^ sum[W-1];
   assign rr_ptr_next = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid_reg <= 1'b0;
         res_sum_reg   <= '0;
         res_id_reg    <= '0;
         res_carry_reg <= 1'b0;
         res_ovf_reg   <= 1'b0;
         res_zero_reg  <= 1'b0;
         rr_ptr_reg    <= '0;
         lock_en_reg   <= 1'b0;
         lock_id_reg   <= '0;
      end else if (accept) begin
         res_valid_reg <= 1'b1;
         res_sum_reg   <= sum;
         res_id_reg    <= grant_id;
         res_carry_reg <= cout;
         res_ovf_reg   <= cout ^ cin_msb;
         res_zero_reg  <= (sum == '0);
         if (lock_sel) begin
            lock_en_reg <= 1'b1;
            lock_id_reg <= grant_id;
         end else begin
            lock_en_reg <= 1'b0;
            rr_ptr_reg  <= rr_ptr_next;
         end
      end else if (res_ready) begin
         res_valid_reg <= 1'b0;
      end
   end

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_carry
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               carry_q_reg[gi] <= 1'b0;
            else if (accept && grant[gi])
               carry_q_reg[gi] <= cout;
         end
      end
   endgenerate

   assign res_valid = res_valid_reg;
   assign res_sum   = res_sum_reg;
   assign res_id    = res_id_reg;
   assign res_carry = res_carry_reg;
   assign res_ovf   = res_ovf_reg;
   assign res_zero  = res_zero_reg;

endmodule
